// File: rtl/counter_stepper.sv
// counter_stepper: command-side driver for a saturating up/down step counter.
// Accepts a target value and issues single-cycle en/upnotdown pulses until the
// counter value is within one stepwidth of the target, then reports completion.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, target     command request; target latched when start is accepted in IDLE
//   current           counter value (counter out)
//   stepwidth         counter step size (counter stepwidth_out)
//   abort             abort request (only with COUNTER_STEPPER_ABORT_EN defined)
//   en, upnotdown     step pulse and direction to the counter
//   busy, done        command in progress / 1-cycle completion pulse
//   status            00 ok, 01 stalled, 10 timeout, 11 aborted; held until next start
//   steps             pulses issued for the current/last command
//
// Optional feature: define COUNTER_STEPPER_ABORT_EN to add the abort input.
module counter_stepper #(
   parameter int unsigned WIDTH     = 16,
   parameter int unsigned SETTLE    = 1,
   parameter int unsigned MAX_STEPS = 1024
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] target,
   input  logic [WIDTH-1:0] current,
   input  logic [WIDTH-1:0] stepwidth,
`ifdef COUNTER_STEPPER_ABORT_EN
   input  logic             abort,
`endif
   output logic             en,
   output logic             upnotdown,
   output logic             busy,
   output logic             done,
   output logic [1:0]       status,
   output logic [WIDTH-1:0] steps
);

   localparam int unsigned WAIT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   localparam logic [1:0] ST_OK      = 2'b00;
   localparam logic [1:0] ST_STALLED = 2'b01;
   localparam logic [1:0] ST_TIMEOUT = 2'b10;
   localparam logic [1:0] ST_ABORTED = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_EVAL,
      S_PULSE,
      S_WAIT,
      S_FINISH
   } state_t;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  tgt_q, tgt_d;
   logic [WIDTH-1:0]  prev_q, prev_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [WIDTH:0]    diff;
   logic              abort_req;
   logic              upnotdown_d;
   logic [1:0]        status_d;
   logic [WIDTH-1:0]  steps_d;

`ifdef COUNTER_STEPPER_ABORT_EN
   assign abort_req = abort;
`else
   assign abort_req = 1'b0;
`endif

   // Next-state and next-output logic
   always_comb begin
      state_d     = state_q;
      tgt_d       = tgt_q;
      prev_d      = prev_q;
      wait_d      = wait_q;
      upnotdown_d = upnotdown;
      status_d    = status;
      steps_d     = steps;
      diff        = '0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               tgt_d    = target;
               steps_d  = '0;
               status_d = ST_OK;
               state_d  = S_EVAL;
            end
         end

         S_EVAL: begin
            // Extra bit keeps the magnitude exact across the full unsigned range
            diff = (tgt_q >= current) ? ({1'b0, tgt_q} - {1'b0, current})
                                      : ({1'b0, current} - {1'b0, tgt_q});
            if (abort_req) begin
               status_d = ST_ABORTED;
               state_d  = S_FINISH;
            end else if ((diff < {1'b0, stepwidth}) || (stepwidth == '0)) begin
               status_d = ST_OK;
               state_d  = S_FINISH;
            end else if (steps == WIDTH'(MAX_STEPS)) begin
               status_d = ST_TIMEOUT;
               state_d  = S_FINISH;
            end else begin
               upnotdown_d = (tgt_q > current);
               prev_d      = current;
               wait_d      = '0;
               state_d     = S_PULSE;
            end
         end

         S_PULSE: begin
            // The pulse already on the wire is always counted, even on abort
            steps_d = steps + WIDTH'(1);
            if (abort_req) begin
               status_d = ST_ABORTED;
               state_d  = S_FINISH;
            end else begin
               state_d = S_WAIT;
            end
         end

         S_WAIT: begin
            if (abort_req) begin
               status_d = ST_ABORTED;
               state_d  = S_FINISH;
            end else if (wait_q == WAIT_W'(SETTLE - 1)) begin
               // No movement after a pulse means the counter is saturated or frozen
               if (current == prev_q) begin
                  status_d = ST_STALLED;
                  state_d  = S_FINISH;
               end else begin
                  state_d = S_EVAL;
               end
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end

         S_FINISH: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and registered outputs; en/done/busy follow the state being entered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         tgt_q     <= '0;
         prev_q    <= '0;
         wait_q    <= '0;
         en        <= 1'b0;
         upnotdown <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         status    <= ST_OK;
         steps     <= '0;
      end else begin
         state_q   <= state_d;
         tgt_q     <= tgt_d;
         prev_q    <= prev_d;
         wait_q    <= wait_d;
         en        <= (state_d == S_PULSE);
         upnotdown <= upnotdown_d;
         busy      <= (state_d != S_IDLE);
         done      <= (state_d == S_FINISH);
         status    <= status_d;
         steps     <= steps_d;
      end
   end

endmodule

// File: tb/tb_counter_stepper.sv
// Testbench for counter_stepper with a behavioural saturating counter model.
module tb_counter_stepper;

   localparam int unsigned WIDTH     = 16;
   localparam int unsigned SETTLE    = 1;
   localparam int unsigned MAX_STEPS = 4;

   typedef struct {
      logic [1:0]  status;
      logic [15:0] steps;
      logic [15:0] cur;
      logic        dir;
   } exp_t;

   exp_t sb_q[$];

   logic        clk      = 1'b0;
   logic        rst_n    = 1'b0;
   logic        start    = 1'b0;
   logic [15:0] target   = '0;
   logic [15:0] cur      = '0;
   logic [15:0] sw       = 16'd100;
   logic        load_req = 1'b0;
   logic [15:0] load_val = '0;
   logic        freeze   = 1'b0;
`ifdef COUNTER_STEPPER_ABORT_EN
   logic        abort    = 1'b0;
`endif

   logic        en, upnotdown, busy, done;
   logic [1:0]  status;
   logic [15:0] steps;

   int n_checks = 0;
   int n_fail   = 0;

   counter_stepper #(
      .WIDTH     (WIDTH),
      .SETTLE    (SETTLE),
      .MAX_STEPS (MAX_STEPS)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .target    (target),
      .current   (cur),
      .stepwidth (sw),
`ifdef COUNTER_STEPPER_ABORT_EN
      .abort     (abort),
`endif
      .en        (en),
      .upnotdown (upnotdown),
      .busy      (busy),
      .done      (done),
      .status    (status),
      .steps     (steps)
   );

   always #5 clk = ~clk;

   // Saturating up/down counter model; freeze emulates a stuck counter
   always @(posedge clk) begin
      if (load_req) begin
         cur <= load_val;
      end else if (en && !freeze) begin
         if (upnotdown) cur <= (cur > 16'hFFFF - sw) ? 16'hFFFF : cur + sw;
         else           cur <= (cur < sw) ? 16'd0 : cur - sw;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic load_counter(input logic [15:0] v, input logic frz);
      load_val = v;
      load_req = 1'b1;
      freeze   = frz;
      @(posedge clk); #1;
      load_req = 1'b0;
   endtask

   // Run one command and compare the completed result against the scoreboard
   task automatic run_cmd(input string name, input logic [15:0] c0, input logic [15:0] t,
                          input logic frz, input logic [1:0] e_status,
                          input logic [15:0] e_steps, input logic [15:0] e_cur,
                          input logic e_dir, input int exp_lat);
      exp_t e, r;
      int   pulses  = 0;
      int   dir_err = 0;
      int   dbl     = 0;
      int   cyc     = 0;
      bit   got     = 0;
      bit   prev_en = 0;
      load_counter(c0, frz);
      target   = t;
      e.status = e_status;
      e.steps  = e_steps;
      e.cur    = e_cur;
      e.dir    = e_dir;
      sb_q.push_back(e);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cyc   = 1;
      while (!got && cyc < 200) begin
         if (en) begin
            pulses++;
            if (upnotdown !== e_dir) dir_err++;
            if (prev_en) dbl++;
         end
         prev_en = en;
         if (done) begin
            got = 1;
            r   = sb_q.pop_front();
            check({name, " status"}, 32'(status), 32'(r.status));
            check({name, " steps"},  32'(steps),  32'(r.steps));
            check({name, " pulses"}, 32'(pulses), 32'(r.steps));
            check({name, " current"}, 32'(cur),   32'(r.cur));
            check({name, " dir_errors"}, 32'(dir_err), 32'd0);
            check({name, " en_multi_cycle"}, 32'(dbl), 32'd0);
            if (exp_lat >= 0) check({name, " latency"}, 32'(cyc), 32'(exp_lat));
         end else begin
            @(posedge clk); #1;
            cyc++;
         end
      end
      if (!got) begin
         check({name, " done_timeout"}, 32'd0, 32'd1);
         if (sb_q.size() > 0) void'(sb_q.pop_front());
      end else begin
         @(posedge clk); #1;
         check({name, " done_after"},  32'(done),   32'd0);
         check({name, " busy_after"},  32'(busy),   32'd0);
         check({name, " status_hold"}, 32'(status), 32'(e_status));
      end
   endtask

   initial begin
      int cnt;
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("reset en",        32'(en),        32'd0);
      check("reset upnotdown", 32'(upnotdown), 32'd0);
      check("reset busy",      32'(busy),      32'd0);
      check("reset done",      32'(done),      32'd0);
      check("reset status",    32'(status),    32'd0);
      check("reset steps",     32'(steps),     32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_cmd("t1_up",      16'd0,     16'd350,   1'b0, 2'b00, 16'd3, 16'd300, 1'b1, -1);
      run_cmd("t2_down",    16'd500,   16'd120,   1'b0, 2'b00, 16'd3, 16'd200, 1'b0, -1);
      run_cmd("t3_deadband",16'd65500, 16'd65535, 1'b0, 2'b00, 16'd0, 16'd65500, 1'b1, 2);
      run_cmd("t3b_equal",  16'd200,   16'd200,   1'b0, 2'b00, 16'd0, 16'd200, 1'b0, 2);
      run_cmd("t4_stall",   16'd0,     16'd1000,  1'b1, 2'b01, 16'd1, 16'd0,   1'b1, -1);
      run_cmd("t5_timeout", 16'd0,     16'd1000,  1'b0, 2'b10, 16'd4, 16'd400, 1'b1, -1);
      run_cmd("t5b_sat_top",16'd65500, 16'd0,     1'b0, 2'b10, 16'd4, 16'd65100, 1'b0, -1);

      // Reset asserted in the middle of a pulse
      load_counter(16'd0, 1'b0);
      target = 16'd350;
      start  = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cnt   = 0;
      while (!en && cnt < 50) begin
         @(posedge clk); #1;
         cnt++;
      end
      check("t6 pulse_seen", 32'(en), 32'd1);
      rst_n = 1'b0;
      #1;
      check("t6 en",        32'(en),        32'd0);
      check("t6 upnotdown", 32'(upnotdown), 32'd0);
      check("t6 busy",      32'(busy),      32'd0);
      check("t6 done",      32'(done),      32'd0);
      check("t6 status",    32'(status),    32'd0);
      check("t6 steps",     32'(steps),     32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("t6 no_resume_en",   32'(en),   32'd0);
      check("t6 no_resume_busy", 32'(busy), 32'd0);

`ifdef COUNTER_STEPPER_ABORT_EN
      // Abort sampled in WAIT after the second pulse
      load_counter(16'd0, 1'b0);
      target = 16'd1000;
      start  = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cnt   = 0;
      begin
         int seen = 0;
         while (seen < 2 && cnt < 50) begin
            if (en) seen++;
            if (seen < 2) begin
               @(posedge clk); #1;
               cnt++;
            end
         end
         check("t7 second_pulse", 32'(seen), 32'd2);
      end
      @(posedge clk); #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check("t7 done",   32'(done),   32'd1);
      check("t7 status", 32'(status), 32'd3);
      check("t7 steps",  32'(steps),  32'd2);
      @(posedge clk); #1;
      check("t7 status_hold", 32'(status), 32'd3);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
